// File: rtl/spi_tx_byte_feeder_pkg.sv
// Shared definitions for the SPI transmit byte feeder: default geometry,
// FSM state encoding and a small sizing helper.
package spi_tx_byte_feeder_pkg;

  localparam int WORD_W_DEF = 64;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_tx_byte_feeder_if.sv
// Handshake bundle between the crypto core / SPI transmitter side and the
// byte feeder. The feeder itself sits on the slave modport.
interface spi_tx_byte_feeder_if
  import spi_tx_byte_feeder_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              tx_en;
  logic [7:0]        tx_byte;
  logic              tx_sent;
  logic              word_done;
  logic [CNT_W-1:0]  fifo_count;
  logic              busy;

  modport master (
    output in_valid, in_data, tx_sent,
    input  in_ready, tx_en, tx_byte, word_done, fifo_count, busy
  );

  modport slave (
    input  in_valid, in_data, tx_sent,
    output in_ready, tx_en, tx_byte, word_done, fifo_count, busy
  );

endinterface

// File: rtl/spi_tx_byte_feeder_sync_word_fifo.sv
// Single-clock word FIFO with occupancy count. Pushes while full and pops
// while empty are ignored; pointers wrap naturally since DEPTH is a power of two.
module sync_word_fifo
  import spi_tx_byte_feeder_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WORD_W-1:0]       push_data,
  input  logic                    pop,
  output logic [WORD_W-1:0]       pop_data,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_tx_byte_feeder.sv
// Feeds buffered cipher words to the SPI transmitter one byte at a time,
// most significant byte first, using a tx_en / tx_sent handshake.
module spi_tx_byte_feeder
  import spi_tx_byte_feeder_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_tx_byte_feeder_if.slave   bus
);
  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  state_t            state_r;
  logic [WORD_W-1:0] shift_r;
  logic [WORD_W-1:0] next_shift_s;
  logic [IDX_W-1:0]  idx_r;
  logic [7:0]        tx_byte_r;
  logic              word_done_r;
  logic              pop_s;
  logic [WORD_W-1:0] pop_data_s;
  logic [CNT_W-1:0]  count_s;
  logic              full_s;
  logic              empty_s;

  sync_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.in_valid),
    .push_data (bus.in_data),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Only the idle state ever takes a word out of the FIFO.
  assign pop_s        = (state_r == IDLE) && !empty_s;
  assign next_shift_s = shift_r << 4'd8;

  assign bus.in_ready   = !full_s;
  assign bus.fifo_count = count_s;
  assign bus.tx_en      = (state_r == SEND);
  assign bus.tx_byte    = tx_byte_r;
  assign bus.word_done  = word_done_r;
  assign bus.busy       = (state_r != IDLE) || !empty_s;

  // Byte sequencer: load a word, strobe each byte, wait for its completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      shift_r     <= {WORD_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      tx_byte_r   <= 8'd0;
      word_done_r <= 1'b0;
    end else begin
      word_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            shift_r   <= pop_data_s;
            idx_r     <= {IDX_W{1'b0}};
            tx_byte_r <= pop_data_s[WORD_W-1 -: 8];
            state_r   <= SEND;
          end
        end
        SEND: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (bus.tx_sent) begin
            if (idx_r == LAST_IDX) begin
              word_done_r <= 1'b1;
              state_r     <= IDLE;
            end else begin
              shift_r   <= next_shift_s;
              idx_r     <= idx_r + IDX_W'(1);
              tx_byte_r <= next_shift_s[WORD_W-1 -: 8];
              state_r   <= SEND;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_byte_feeder.sv
// Scoreboard bench for spi_tx_byte_feeder: accepted words queue their bytes,
// a monitor pops and compares on every tx_en, and an optional responder
// answers each tx_en with tx_sent after a programmable delay.
module tb_spi_tx_byte_feeder;
  import spi_tx_byte_feeder_pkg::*;

  localparam int WORD_W = 64;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_tx_byte_feeder_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

  spi_tx_byte_feeder #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_bytes [$];
  int done_seen = 0;
  int en_seen   = 0;
  int bytes_in_word = 0;
  bit auto_resp = 1'b0;
  int resp_delay = 10;
  logic man_sent  = 1'b0;
  logic auto_sent = 1'b0;

  assign bus.tx_sent = man_sent | auto_sent;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one word and hold it until accepted; queue its bytes MSB first.
  task automatic push_word(input logic [63:0] w);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (bus.in_ready !== 1'b1 && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (bus.in_ready !== 1'b1) check("push_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    for (int b = 7; b >= 0; b--) exp_bytes.push_back(w[b*8 +: 8]);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (bus.busy !== 1'b0 && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    check({name, "_idle"}, bus.busy, 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_en();
    int t;
    t = 0;
    while (bus.tx_en !== 1'b1 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (bus.tx_en !== 1'b1) check("tx_en_timeout", 64'd0, 64'd1);
  endtask

  task automatic manual_sent();
    repeat (2) @(posedge clk);
    #1 man_sent = 1'b1;
    @(posedge clk); #1 man_sent = 1'b0;
  endtask

  // Responder: answer each tx_en with a one-cycle tx_sent after resp_delay edges.
  initial begin
    forever begin
      if (auto_resp && bus.tx_en === 1'b1) begin
        repeat (resp_delay) @(posedge clk);
        #1 auto_sent = 1'b1;
        @(posedge clk); #1 auto_sent = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Monitor: compare every presented byte and every word_done against the scoreboard.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bytes_in_word = 0;
        exp_bytes.delete();
      end else begin
        if (bus.tx_en === 1'b1) begin
          en_seen++;
          if (exp_bytes.size() == 0) begin
            check("tx_en_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_bytes.pop_front();
            check("tx_byte", bus.tx_byte, e);
          end
          bytes_in_word++;
        end
        if (bus.word_done === 1'b1) begin
          done_seen++;
          check("bytes_per_word", bytes_in_word, 64'd8);
          bytes_in_word = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int done_base;
    int en_base;
    logic [63:0] burst [5];
    burst = '{64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7, 64'hC0C1C2C3C4C5C6C7,
              64'hD0D1D2D3D4D5D6D7, 64'hE0E1E2E3E4E5E6E7};
    bus.in_valid = 1'b0;
    bus.in_data  = 64'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", bus.tx_en, 64'd0);
    check("rst_tx_byte", bus.tx_byte, 64'd0);
    check("rst_word_done", bus.word_done, 64'd0);
    check("rst_in_ready", bus.in_ready, 64'd1);
    check("rst_busy", bus.busy, 64'd0);
    check("rst_count", bus.fifo_count, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset asserted mid-WAIT with two words buffered.
    auto_resp = 1'b0;
    push_word(64'h1111111111111111);
    wait_tx_en();
    push_word(64'h2222222222222222);
    push_word(64'h3333333333333333);
    check("t1_busy", bus.busy, 64'd1);
    check("t1_count", bus.fifo_count, 64'd2);
    #3 rst = 1'b1;
    #1;
    check("t1_rst_tx_en", bus.tx_en, 64'd0);
    check("t1_rst_count", bus.fifo_count, 64'd0);
    check("t1_rst_in_ready", bus.in_ready, 64'd1);
    check("t1_rst_busy", bus.busy, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t1_after_busy", bus.busy, 64'd0);

    // Single word, slow transmitter.
    done_base = done_seen;
    en_base = en_seen;
    resp_delay = 10;
    auto_resp = 1'b1;
    push_word(64'h0102030405060708);
    wait_idle("t2");
    check("t2_tx_en_pulses", en_seen - en_base, 64'd8);
    check("t2_word_done", done_seen - done_base, 64'd1);

    // Burst of five words against a slow transmitter.
    done_base = done_seen;
    resp_delay = 6;
    for (int i = 0; i < 5; i++) push_word(burst[i]);
    check("t3_in_ready", bus.in_ready, 64'd0);
    check("t3_count", bus.fifo_count, 64'd4);
    wait_idle("t3");
    check("t3_word_done", done_seen - done_base, 64'd5);
    check("t3_drained", exp_bytes.size(), 64'd0);

    // Push and pop in the same cycle at count=2.
    done_base = done_seen;
    auto_resp = 1'b0;
    push_word(64'h4041424344454647);
    wait_tx_en();
    push_word(64'h5051525354555657);
    push_word(64'h6061626364656667);
    for (int i = 0; i < 8; i++) manual_sent();
    check("t4_count_before", bus.fifo_count, 64'd2);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h7071727374757677;
    auto_resp = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int b = 7; b >= 0; b--) exp_bytes.push_back(bus.in_data[b*8 +: 8]);
    check("t4_count_after", bus.fifo_count, 64'd2);
    check("t4_popped", bus.tx_en, 64'd1);
    wait_idle("t4");
    check("t4_word_done", done_seen - done_base, 64'd4);

    // Spurious tx_sent in IDLE and in SEND.
    done_base = done_seen;
    auto_resp = 1'b0;
    man_sent = 1'b1;
    @(posedge clk); #1 man_sent = 1'b0;
    check("t5_idle_busy", bus.busy, 64'd0);
    push_word(64'hC1C2C3C4C5C6C7C8);
    wait_tx_en();
    man_sent = 1'b1;
    @(posedge clk); #1 man_sent = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_advance", bus.tx_en, 64'd0);
    check("t5_hold_byte", bus.tx_byte, 64'hC1);
    check("t5_busy", bus.busy, 64'd1);
    auto_resp = 1'b1;
    man_sent = 1'b1;
    @(posedge clk); #1 man_sent = 1'b0;
    wait_idle("t5");
    check("t5_word_done", done_seen - done_base, 64'd1);

    // FIFO wrap with twelve words streamed through.
    done_base = done_seen;
    resp_delay = 2;
    for (int i = 0; i < 12; i++)
      push_word({8{8'(i)}} ^ 64'h0011223344556677);
    wait_idle("t6");
    check("t6_word_done", done_seen - done_base, 64'd12);
    check("t6_drained", exp_bytes.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
